// File: rtl/mxv_result_tx_pkg.sv
// Shared types and constants for the matrix-by-vector reply framer.
// State encodings are plain localparams so older tools and waveform scripts read them directly.
package mxv_result_tx_pkg;

   typedef logic [7:0]   word_lenght_t;
   typedef word_lenght_t byte_t;

   localparam byte_t SOF_DEFAULT = 8'hFE;
   localparam byte_t EOF_DEFAULT = 8'hEF;

   localparam int VEC_N_W = 4;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE     = 4'd0;
   localparam state_t S_LOAD     = 4'd1;
   localparam state_t S_WAIT_SOF = 4'd2;
   localparam state_t S_WAIT_LEN = 4'd3;
   localparam state_t S_FETCH    = 4'd4;
   localparam state_t S_LATCH    = 4'd5;
   localparam state_t S_SEND_B   = 4'd6;
   localparam state_t S_WAIT_B   = 4'd7;
   localparam state_t S_SEND_EOF = 4'd8;
   localparam state_t S_WAIT_EOF = 4'd9;
   localparam state_t S_FIN      = 4'd10;

   // LEN byte is the payload byte count, truncated to 8 bits.
   function automatic byte_t frame_len(input logic [VEC_N_W-1:0] n, input int bytes_per_word);
      int len;
      len = int'(n) * bytes_per_word;
      return len[7:0];
   endfunction

endpackage

// File: rtl/mxv_tx_shift.sv
// Parallel-load, left-shift byte serialiser holding one result word.
// o_byte is the top byte as it will stand after this edge, so the caller can register it alongside the load/shift.
module mxv_tx_shift
   import mxv_result_tx_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output byte_t            o_byte
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_sr_nxt;

   always_comb begin
      // NOTE: assign a default first so every path drives w_sr_nxt and no latch is inferred.
      w_sr_nxt = r_sr;
      if (i_load) begin
         w_sr_nxt = i_data;
      end else if (i_shift) begin
         w_sr_nxt = r_sr << 8;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst_n) begin
         r_sr <= '0;
      end else begin
         r_sr <= w_sr_nxt;
      end
   end

   assign o_byte = w_sr_nxt[WIDTH-1 -: 8];

endmodule

// File: rtl/mxv_result_tx.sv
// Reply framer: reads N result words and sends SOF, LEN, payload (MSB first), EOF to the UART.
// Every byte is issued with a one-cycle TX_START and the next one waits for the matching TX_DONE.
module mxv_result_tx
   import mxv_result_tx_pkg::*;
#(
   parameter int    RES_WIDTH = 16,
   parameter int    MAX_N     = 8,
   parameter byte_t SOF_BYTE  = SOF_DEFAULT,
   parameter byte_t EOF_BYTE  = EOF_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     START,
   input  logic [VEC_N_W-1:0]       VEC_N,
   output logic [$clog2(MAX_N)-1:0] RES_ADDR,
   input  logic [RES_WIDTH-1:0]     RES_DATA,
   output word_lenght_t             TX_DATA,
   output logic                     TX_START,
   input  logic                     TX_DONE,
   output logic                     BUSY,
   output logic                     DONE
);

   localparam int                 ADDR_W    = $clog2(MAX_N);
   localparam int                 BPW       = RES_WIDTH / 8;
   localparam logic [1:0]         LAST_BYTE = 2'(BPW - 1);
   localparam logic [VEC_N_W-1:0] N_MAX     = VEC_N_W'(MAX_N);

   state_t             r_state;
   logic [VEC_N_W-1:0] r_n;
   logic [ADDR_W-1:0]  r_word_idx;
   logic [1:0]         r_byte_idx;
   byte_t              r_tx_data;
   logic               r_tx_start;

   logic [VEC_N_W-1:0] w_n_clamped;
   logic               w_last_word;
   logic               w_last_byte;
   logic               w_load;
   logic               w_shift;
   byte_t              w_sr_byte;

   assign w_n_clamped = (VEC_N > N_MAX) ? N_MAX : VEC_N;
   assign w_last_word = (VEC_N_W'(r_word_idx) + VEC_N_W'(1)) == r_n;
   assign w_last_byte = (r_byte_idx == LAST_BYTE);
   assign w_load      = (r_state == S_LATCH);
   assign w_shift     = (r_state == S_WAIT_B) && TX_DONE;

   mxv_tx_shift #(
      .WIDTH (RES_WIDTH)
   ) u_shift (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (RES_DATA),
      .o_byte  (w_sr_byte)
   );

   // TX_START/TX_DATA are registered on the transition into the sending cycle,
   // which gives the one-cycle TX_DONE-to-TX_START turnaround.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_n        <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_n        <= w_n_clamped;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  r_tx_data  <= SOF_BYTE;
                  r_tx_start <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: r_state <= S_WAIT_SOF;
            S_WAIT_SOF: begin
               if (TX_DONE) begin
                  r_tx_data  <= frame_len(r_n, BPW);
                  r_tx_start <= 1'b1;
                  r_state    <= S_WAIT_LEN;
               end
            end
            S_WAIT_LEN: begin
               if (TX_DONE) begin
                  if (r_n != '0) begin
                     r_state <= S_FETCH;
                  end else begin
                     r_tx_data  <= EOF_BYTE;
                     r_tx_start <= 1'b1;
                     r_state    <= S_SEND_EOF;
                  end
               end
            end
            S_FETCH: r_state <= S_LATCH;
            S_LATCH: begin
               r_tx_data  <= w_sr_byte;
               r_tx_start <= 1'b1;
               r_state    <= S_SEND_B;
            end
            S_SEND_B: r_state <= S_WAIT_B;
            S_WAIT_B: begin
               if (TX_DONE) begin
                  if (!w_last_byte) begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_tx_data  <= w_sr_byte;
                     r_tx_start <= 1'b1;
                     r_state    <= S_SEND_B;
                  end else if (!w_last_word) begin
                     r_byte_idx <= '0;
                     r_word_idx <= r_word_idx + ADDR_W'(1);
                     r_state    <= S_FETCH;
                  end else begin
                     r_tx_data  <= EOF_BYTE;
                     r_tx_start <= 1'b1;
                     r_state    <= S_SEND_EOF;
                  end
               end
            end
            S_SEND_EOF: r_state <= S_WAIT_EOF;
            S_WAIT_EOF: begin
               if (TX_DONE) begin
                  r_state <= S_FIN;
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign RES_ADDR = r_word_idx;
   assign TX_DATA  = r_tx_data;
   assign TX_START = r_tx_start;
   assign BUSY     = (r_state != S_IDLE);
   assign DONE     = (r_state == S_FIN);

endmodule

// File: tb/tb_mxv_result_tx.sv
// Directed bench for mxv_result_tx: a UART responder with programmable TX_DONE delay and a registered result buffer.
module tb_mxv_result_tx;
   import mxv_result_tx_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        START;
   logic [3:0]  VEC_N;
   logic [2:0]  RES_ADDR;
   logic [15:0] RES_DATA;
   byte_t       TX_DATA;
   logic        TX_START;
   logic        TX_DONE;
   logic        BUSY;
   logic        DONE;

   mxv_result_tx dut (
      .clk      (clk),
      .rst      (rst),
      .START    (START),
      .VEC_N    (VEC_N),
      .RES_ADDR (RES_ADDR),
      .RES_DATA (RES_DATA),
      .TX_DATA  (TX_DATA),
      .TX_START (TX_START),
      .TX_DONE  (TX_DONE),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:7];
   always @(posedge clk) RES_DATA <= mem[RES_ADDR];

   int    n_pass = 0;
   int    n_total = 0;
   byte_t cap[$];
   int    cap_cyc[$];
   byte_t cur;
   bit    pending;
   int    cnt;
   int    cyc;
   int    stab_err, dup_err, done_cnt, busy_err, wrap_err, max_addr;
   bit    timed_out, tail_busy_err;
   logic [2:0] prev_addr;

   function automatic string fmt_bytes(input byte_t q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   function automatic int first_diff(input byte_t exp[$]);
      for (int i = 0; i < exp.size(); i++) begin
         if (i >= cap.size()) return i;
         if (cap[i] !== exp[i]) return i;
      end
      if (cap.size() != exp.size()) return exp.size();
      return -1;
   endfunction

   function automatic int gap(input int i);
      if (i + 1 >= cap_cyc.size()) return -1;
      return cap_cyc[i+1] - cap_cyc[i];
   endfunction

   // One negedge of the UART responder: capture on TX_START, answer TX_DONE after delay cycles.
   task automatic uart_step(input int delay);
      TX_DONE = 1'b0;
      if (pending) begin
         if (TX_DATA !== cur) stab_err++;
         if (TX_START !== 1'b0) dup_err++;
         cnt--;
         if (cnt == 0) begin
            TX_DONE = 1'b1;
            pending = 1'b0;
         end
      end else if (TX_START === 1'b1) begin
         cap.push_back(TX_DATA);
         cap_cyc.push_back(cyc);
         cur     = TX_DATA;
         pending = 1'b1;
         cnt     = delay;
      end
      if (DONE === 1'b1) done_cnt++;
      if (RES_ADDR < prev_addr) wrap_err++;
      if (int'(RES_ADDR) > max_addr) max_addr = int'(RES_ADDR);
      prev_addr = RES_ADDR;
   endtask

   task automatic send_frame(input logic [3:0] vn, input int delay, input bit stray, input int abort_at);
      cap.delete();
      cap_cyc.delete();
      pending = 0; cnt = 0; cyc = 0;
      stab_err = 0; dup_err = 0; done_cnt = 0; busy_err = 0; wrap_err = 0; max_addr = 0;
      timed_out = 0; tail_busy_err = 0;
      @(negedge clk);
      VEC_N   = vn;
      START   = 1'b1;
      TX_DONE = stray;
      while (done_cnt == 0) begin
         @(negedge clk);
         cyc++;
         START = 1'b0;
         if (cyc == 1) prev_addr = RES_ADDR;
         uart_step(delay);
         if (BUSY !== 1'b1) busy_err++;
         if (stray && !pending && TX_START !== 1'b1 && BUSY === 1'b1) TX_DONE = 1'b1;
         if (stray && pending && cap.size() == 2 && cnt == 3) begin
            START = 1'b1;
            VEC_N = 4'd5;
         end
         if (abort_at > 0 && cap.size() == abort_at) return;
         if (cyc >= 3000) begin
            timed_out = 1'b1;
            return;
         end
      end
      @(negedge clk);
      cyc++;
      uart_step(delay);
      if (BUSY !== 1'b0) tail_busy_err = 1'b1;
      repeat (4) begin
         @(negedge clk);
         cyc++;
         uart_step(delay);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; START = 1'b0; TX_DONE = 1'b0; VEC_N = '0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      n_total++; if (TX_DATA !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", TX_DATA); else n_pass++;
      n_total++; if (TX_START !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", TX_START); else n_pass++;
      n_total++; if (RES_ADDR !== 3'd0) $display("FAIL reset_res_addr: got %0d want 0", RES_ADDR); else n_pass++;
      n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
      n_total++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_empty();
      byte_t exp[$];
      exp = '{8'hFE, 8'h00, 8'hEF};
      send_frame(4'd0, 3, 1'b0, 0);
      n_total++; if (timed_out) $display("FAIL empty_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL empty_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if (max_addr != 0) $display("FAIL empty_addr: got max %0d want 0", max_addr); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL empty_done: got %0d pulses want 1", done_cnt); else n_pass++;
   endtask

   task automatic test_basic();
      byte_t exp[$];
      exp = '{8'hFE, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hEF};
      mem[0] = 16'h1234;
      mem[1] = 16'hABCD;
      send_frame(4'd2, 20, 1'b0, 0);
      n_total++; if (timed_out) $display("FAIL basic_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL basic_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if ((cap_cyc.size() > 0 ? cap_cyc[0] : -1) != 1) $display("FAIL basic_start_latency: got %0d want 1", cap_cyc.size() > 0 ? cap_cyc[0] : -1); else n_pass++;
      n_total++; if (gap(1) != 23) $display("FAIL basic_gap_len_to_data: got %0d want 23", gap(1)); else n_pass++;
      n_total++; if (gap(2) != 21) $display("FAIL basic_gap_in_word: got %0d want 21", gap(2)); else n_pass++;
      n_total++; if (gap(3) != 23) $display("FAIL basic_gap_word_boundary: got %0d want 23", gap(3)); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else n_pass++;
      n_total++; if (busy_err != 0) $display("FAIL basic_busy: got %0d low cycles want 0", busy_err); else n_pass++;
      n_total++; if (tail_busy_err) $display("FAIL basic_busy_drop: got 1 after FIN want 0"); else n_pass++;
      n_total++; if (stab_err + dup_err != 0) $display("FAIL basic_handshake: got %0d/%0d want 0/0", stab_err, dup_err); else n_pass++;
   endtask

   task automatic test_clamp();
      byte_t exp[$];
      exp = '{8'hFE, 8'h10};
      for (int i = 0; i < 8; i++) begin
         mem[i] = 16'(i + 1);
         exp.push_back(8'h00);
         exp.push_back(8'(i + 1));
      end
      exp.push_back(8'hEF);
      send_frame(4'd12, 2, 1'b0, 0);
      n_total++; if (timed_out) $display("FAIL clamp_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL clamp_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if (max_addr != 7) $display("FAIL clamp_addr_max: got %0d want 7", max_addr); else n_pass++;
      n_total++; if (wrap_err != 0) $display("FAIL clamp_addr_wrap: got %0d wraps want 0", wrap_err); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL clamp_done: got %0d pulses want 1", done_cnt); else n_pass++;
   endtask

   task automatic test_ignore();
      byte_t exp[$];
      exp = '{8'hFE, 8'h02, 8'h5A, 8'hA5, 8'hEF};
      mem[0] = 16'h5AA5;
      send_frame(4'd1, 6, 1'b1, 0);
      n_total++; if (timed_out) $display("FAIL ignore_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL ignore_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL ignore_done: got %0d pulses want 1", done_cnt); else n_pass++;
      n_total++; if (stab_err + dup_err != 0) $display("FAIL ignore_handshake: got %0d/%0d want 0/0", stab_err, dup_err); else n_pass++;
      VEC_N = 4'd0;
   endtask

   task automatic test_abort();
      byte_t exp[$];
      exp = '{8'hFE, 8'h02, 8'h00, 8'hEF, 8'hEF};
      mem[0] = 16'h1234;
      mem[1] = 16'hABCD;
      send_frame(4'd2, 20, 1'b0, 4);
      #2 rst = 1'b0;
      #1;
      n_total++; if (TX_START !== 1'b0) $display("FAIL abort_tx_start: got %b want 0", TX_START); else n_pass++;
      n_total++; if (TX_DATA !== 8'h00) $display("FAIL abort_tx_data: got %02h want 00", TX_DATA); else n_pass++;
      n_total++; if (RES_ADDR !== 3'd0) $display("FAIL abort_res_addr: got %0d want 0", RES_ADDR); else n_pass++;
      n_total++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else n_pass++;
      n_total++; if (DONE !== 1'b0 || done_cnt != 0) $display("FAIL abort_done: got %b/%0d want 0/0", DONE, done_cnt); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mem[0] = 16'h00EF;
      send_frame(4'd1, 4, 1'b0, 0);
      n_total++; if (timed_out) $display("FAIL abort_restart_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL abort_restart_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL abort_restart_done: got %0d pulses want 1", done_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      byte_t exp[$];
      exp = '{8'hFE, 8'h06, 8'hFE, 8'h01, 8'h02, 8'hEF, 8'h7F, 8'h80, 8'hEF};
      mem[0] = 16'hFE01;
      mem[1] = 16'h02EF;
      mem[2] = 16'h7F80;
      send_frame(4'd3, 1, 1'b0, 0);
      n_total++; if (timed_out) $display("FAIL b2b_timeout: frame did not finish"); else n_pass++;
      n_total++; if (first_diff(exp) != -1) $display("FAIL b2b_bytes: got %s want %s", fmt_bytes(cap), fmt_bytes(exp)); else n_pass++;
      n_total++; if (gap(2) != 2) $display("FAIL b2b_gap_in_word: got %0d want 2", gap(2)); else n_pass++;
      n_total++; if (gap(3) != 4) $display("FAIL b2b_gap_word_boundary: got %0d want 4", gap(3)); else n_pass++;
      n_total++; if (stab_err != 0) $display("FAIL b2b_tx_data_stable: got %0d changes want 0", stab_err); else n_pass++;
      n_total++; if (dup_err != 0) $display("FAIL b2b_tx_start_early: got %0d want 0", dup_err); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL b2b_done: got %0d pulses want 1", done_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_basic();
      test_clamp();
      test_ignore();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mxv_result_tx.md
Name: mxv_result_tx

Overview:
Reply-path framer for the matrix-by-vector engine. After an operation completes, it reads the N result words from the result buffer and serialises them into a byte frame for the UART transmitter. The frame is SOF 0xFE, LEN, payload bytes (MSB first), then EOF 0xEF. It mirrors the command frame the receive side accepts (0xFE … 0xEF) and paces every byte on the UART TX done handshake.

Parameters:
RES_WIDTH, 16, result word width in bits; must be 8, 16, 24 or 32.
MAX_N, 8, maximum number of result words (matrix rows).
SOF_BYTE, 8'hFE, start-of-frame byte.
EOF_BYTE, 8'hEF, end-of-frame byte.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
START  in  1  one-cycle pulse: transmit a frame; sampled only in IDLE.
VEC_N  in  4  number of result words; latched on accepted START.
RES_ADDR  out  3  result buffer read address (word index).
RES_DATA  in  RES_WIDTH  result buffer read data; valid 1 cycle after RES_ADDR.
TX_DATA  out  8  byte to the UART transmitter.
TX_START  out  1  one-cycle pulse: UART loads TX_DATA.
TX_DONE  in  1  one-cycle pulse from the UART: byte fully shifted out.
BUSY  out  1  high from accepted START until DONE.
DONE  out  1  one-cycle pulse after EOF's TX_DONE.

Behaviour:
- Reset (async, rst=0): state IDLE. TX_DATA=0, TX_START=0, RES_ADDR=0, BUSY=0, DONE=0. Byte and word counters cleared.
- VEC_N latch: n = VEC_N clamped to MAX_N. VEC_N=0 is legal and gives LEN=0 with no payload.
- LEN byte: n*(RES_WIDTH/8), as an 8-bit value.
- States and transitions:
  IDLE -> LOAD on START.
  LOAD: latch n. Drive TX_DATA=SOF, TX_START=1 for one cycle. -> WAIT_SOF.
  WAIT_SOF: on TX_DONE, drive LEN with TX_START=1. -> WAIT_LEN.
  WAIT_LEN: on TX_DONE -> FETCH if n>0, else SEND_EOF.
  FETCH: drive RES_ADDR=word index. -> LATCH.
  LATCH: register RES_DATA into a shift register. -> SEND_B.
  SEND_B: drive the shift register's top byte with TX_START=1. -> WAIT_B.
  WAIT_B: on TX_DONE, shift left 8 bits.
    - More bytes remain in the word -> SEND_B.
    - Else more words remain -> increment index, FETCH.
    - Else -> SEND_EOF.
  SEND_EOF: drive EOF with TX_START=1. -> WAIT_EOF.
  WAIT_EOF: on TX_DONE -> FIN.
  FIN: DONE=1 for one cycle. -> IDLE.
- Latency: START to first TX_START is 1 cycle. TX_DONE to the next TX_START is 1 cycle within a word, and 3 cycles across a word boundary (FETCH, LATCH, SEND_B).
- TX_DATA holds its value from the TX_START cycle until the matching TX_DONE; it changes only when a new TX_START is issued.
- TX_START is never reasserted before the matching TX_DONE.
- BUSY=1 in every state except IDLE. BUSY drops in the cycle after FIN.
- Boundary and error conditions:
  - START while BUSY: ignored; VEC_N is not re-latched.
  - TX_DONE in any non-WAIT state: ignored.
  - START and TX_DONE in the same IDLE cycle: START accepted, TX_DONE ignored.
  - VEC_N > MAX_N: clamped to MAX_N; LEN reflects the clamped value.
  - The word index never wraps past n-1.
  - Reset mid-frame: immediate abort to IDLE, TX_START low, no DONE pulse. The UART side discards the partial frame.
- Payload values are not checked: payload bytes equal to 0xFE or 0xEF are sent as-is. Framing relies on LEN.

Decomposition:
- Add to Definitions_Package: typedef for the state enum, SOF/EOF constants, byte_t (logic [7:0]). Reuse word_lenght_t for the byte bus.
- One sub-module: mxv_tx_shift. It is a parallel-load, left-shift byte serialiser (load, shift, top byte out) holding the latched RES_DATA.
- Counters and FSM stay in the top.

Test Plan:
1. n=2, RES_WIDTH=16, buffer {0x1234, 0xABCD}, UART model gives TX_DONE 20 cycles after each TX_START -> bytes FE, 04, 12, 34, AB, CD, EF; then one DONE pulse; BUSY high throughout.
2. VEC_N=0 -> bytes FE, 00, EF; RES_ADDR never leaves 0; DONE pulses.
3. VEC_N=12 (clamp), buffer words 0x0001..0x0008 -> LEN=0x10, 16 payload bytes 00 01 … 00 08, RES_ADDR sweeps 0..7 with no wrap.
4. Second START pulse and stray TX_DONE pulses during WAIT_LEN of an n=1 frame -> frame unchanged (FE, 02, data, EF); exactly one DONE.
5. rst low while WAIT_B is pending on the 2nd payload byte -> all outputs at reset values asynchronously. Next START (n=1, 0x00EF) -> fresh frame FE, 02, 00, EF, EF.
6. TX_DONE returned the cycle after each TX_START (back-to-back) -> no byte skipped or duplicated; TX_DATA stable between each TX_START and its TX_DONE.
